nonce_sweep_scheduler: RTL and testbench

Sequences a 16-lane bitcoin hash core across a nonce range. Each batch covers LANES consecutive nonces; the scheduler launches the batch and collects per-lane results. Each result's most-significant hash word is compared against a target, and the lowest hitting nonce is recorded. The block sits between the host/control registers and the hash core, replacing manual per-batch start/poll by software.

---
 rtl/nonce_sweep_scheduler.sv | 166 ++++++++++++++++
 tb/tb_nonce_sweep_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_scheduler.sv
// Walks a nonce range in LANES-wide batches on a hash core and records the lowest
// nonce whose top hash word is below the target.
module nonce_sweep_scheduler #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [31:0]              nonce_lo_i,
  input  logic [31:0]              nonce_hi_i,
  input  logic [31:0]              target_i,
  input  logic                     stop_on_hit_i,
  output logic                     core_start_o,
  output logic [31:0]              core_base_o,
  input  logic                     core_done_i,
  input  logic                     res_valid_i,
  input  logic [$clog2(LANES)-1:0] res_lane_i,
  input  logic [31:0]              res_word_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     found_o,
  output logic [31:0]              found_nonce_o,
  output logic [31:0]              found_word_o,
  output logic [15:0]              batch_count_o,
  output logic                     error_o
);

  localparam int unsigned       TimerW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [32:0]       LanesW    = 33'(LANES);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StEval, StFinish} state_e;

  state_e            state_q, state_d;
  logic [31:0]       base_q, base_d, hi_q, hi_d, target_q, target_d;
  logic              stop_q, stop_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              busy_q, busy_d, done_q, done_d, cs_q, cs_d;
  logic              found_q, found_d, error_q, error_d;
  logic [31:0]       fnonce_q, fnonce_d, fword_q, fword_d;
  logic [15:0]       bcount_q, bcount_d;

  logic [32:0]       res_nonce;
  logic              res_hit;

  // 33-bit sum so a batch straddling 2^32 discards its wrapped lanes.
  assign res_nonce = {1'b0, base_q} + 33'(res_lane_i);
  assign res_hit   = res_valid_i && !res_nonce[32] && (res_nonce[31:0] <= hi_q) &&
                     (res_word_i < target_q) && (!found_q || (res_nonce[31:0] < fnonce_q));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    hi_d     = hi_q;
    target_d = target_q;
    stop_d   = stop_q;
    timer_d  = timer_q;
    busy_d   = busy_q;
    found_d  = found_q;
    fnonce_d = fnonce_q;
    fword_d  = fword_q;
    bcount_d = bcount_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          hi_d     = nonce_hi_i;
          target_d = target_i;
          stop_d   = stop_on_hit_i;
          base_d   = nonce_lo_i;
          found_d  = 1'b0;
          fnonce_d = '0;
          fword_d  = '0;
          bcount_d = '0;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = (nonce_lo_i > nonce_hi_i) ? StFinish : StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = abort_i ? StFinish : StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (res_hit) begin
          found_d  = 1'b1;
          fnonce_d = res_nonce[31:0];
          fword_d  = res_word_i;
        end
        if (abort_i) begin
          state_d = StFinish;
        end else if (core_done_i) begin
          state_d = StEval;
        end else if (timer_q == TimerLast) begin
          error_d = 1'b1;
          state_d = StFinish;
        end
      end
      StEval: begin
        if (bcount_q != 16'hFFFF) bcount_d = bcount_q + 16'd1;
        if (abort_i || (found_q && stop_q) || (({1'b0, base_q} + LanesW) > {1'b0, hi_q})) begin
          state_d = StFinish;
        end else begin
          base_d  = base_q + 32'(LANES);
          state_d = StLaunch;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Pulses are registered so they line up exactly with their state.
    cs_d   = (state_d == StLaunch);
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      hi_q     <= '0;
      target_q <= '0;
      stop_q   <= 1'b0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      found_q  <= 1'b0;
      fnonce_q <= '0;
      fword_q  <= '0;
      bcount_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      hi_q     <= hi_d;
      target_q <= target_d;
      stop_q   <= stop_d;
      timer_q  <= timer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      found_q  <= found_d;
      fnonce_q <= fnonce_d;
      fword_q  <= fword_d;
      bcount_q <= bcount_d;
      error_q  <= error_d;
    end
  end

  assign core_start_o  = cs_q;
  assign core_base_o   = base_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign found_nonce_o = fnonce_q;
  assign found_word_o  = fword_q;
  assign batch_count_o = bcount_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Bench for nonce_sweep_scheduler: a core stub replays per-batch result plans, a sweep
// model predicts launch bases and final results, and a monitor scores DUT outputs.
module tb_nonce_sweep_scheduler;

  localparam int unsigned LANES   = 16;
  localparam int unsigned TIMEOUT = 40;
  localparam int          MaxB    = 8;
  localparam int          LaneW   = $clog2(LANES);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_i, abort_i, stop_on_hit_i;
  logic [31:0]      nonce_lo_i, nonce_hi_i, target_i;
  logic             core_start_o, core_done_i, res_valid_i;
  logic [31:0]      core_base_o, res_word_i;
  logic [LaneW-1:0] res_lane_i;
  logic             busy_o, done_o, found_o, error_o;
  logic [31:0]      found_nonce_o, found_word_o;
  logic [15:0]      batch_count_o;

  always #5 clk = ~clk;

  nonce_sweep_scheduler #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
    .nonce_lo_i(nonce_lo_i), .nonce_hi_i(nonce_hi_i), .target_i(target_i),
    .stop_on_hit_i(stop_on_hit_i), .core_start_o(core_start_o), .core_base_o(core_base_o),
    .core_done_i(core_done_i), .res_valid_i(res_valid_i), .res_lane_i(res_lane_i),
    .res_word_i(res_word_i), .busy_o(busy_o), .done_o(done_o), .found_o(found_o),
    .found_nonce_o(found_nonce_o), .found_word_o(found_word_o),
    .batch_count_o(batch_count_o), .error_o(error_o)
  );

  typedef struct packed {
    logic        found;
    logic [31:0] fn;
    logic [31:0] fw;
    logic [15:0] bc;
    logic        err;
  } exp_t;

  logic [31:0] exp_base[$];
  exp_t        exp_sum[$];
  int          total = 0;
  int          bad = 0;

  int          plan_n[MaxB];
  int          plan_lane[MaxB][LANES];
  logic [31:0] plan_word[MaxB][LANES];
  bit          plan_hang[MaxB];
  int          stub_batch = 0;
  int          cyc = 0;
  int          cs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen or missed with no matching expectation", name);
  endtask

  task automatic clear_plan();
    for (int b = 0; b < MaxB; b++) begin
      plan_n[b]    = 0;
      plan_hang[b] = 1'b0;
    end
  endtask

  task automatic add_res(input int b, input int lane, input logic [31:0] word);
    plan_lane[b][plan_n[b]] = lane;
    plan_word[b][plan_n[b]] = word;
    plan_n[b]++;
  endtask

  // Reference: walk batches with wide arithmetic, keep the lowest in-range hit.
  task automatic model_push(input logic [31:0] lo, input logic [31:0] hi,
                            input logic [31:0] tgt, input logic stop);
    exp_t            e;
    longint unsigned base, nonce;
    e = '0;
    if (lo <= hi) begin
      base = 64'(lo);
      for (int b = 0; b < MaxB; b++) begin
        exp_base.push_back(32'(base));
        if (plan_hang[b]) begin
          e.err = 1'b1;
          break;
        end
        for (int k = 0; k < plan_n[b]; k++) begin
          nonce = base + 64'(plan_lane[b][k]);
          if (nonce <= 64'(hi) && plan_word[b][k] < tgt && (!e.found || nonce < 64'(e.fn))) begin
            e.found = 1'b1;
            e.fn    = 32'(nonce);
            e.fw    = plan_word[b][k];
          end
        end
        e.bc++;
        if ((e.found && stop) || (base + 64'(LANES) > 64'(hi))) break;
        base += 64'(LANES);
      end
    end
    exp_sum.push_back(e);
  endtask

  // Core stub: results start the cycle after launch, optionally with done on the last one.
  initial begin
    res_valid_i = 1'b0;
    core_done_i = 1'b0;
    res_lane_i  = '0;
    res_word_i  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && core_start_o) begin
        int b;
        bit same;
        b = stub_batch;
        stub_batch++;
        if (b < MaxB && !plan_hang[b]) begin
          same = 1'($urandom_range(0, 1));
          @(negedge clk);
          for (int k = 0; k < plan_n[b]; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            res_valid_i = 1'b1;
            res_lane_i  = LaneW'(plan_lane[b][k]);
            res_word_i  = plan_word[b][k];
            core_done_i = same && (k == plan_n[b] - 1);
            @(negedge clk);
            res_valid_i = 1'b0;
            core_done_i = 1'b0;
          end
          if (!(same && plan_n[b] > 0)) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            core_done_i = 1'b1;
            @(negedge clk);
            core_done_i = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: scores every launch and every end of sweep against the queues.
  initial begin
    logic [31:0] mb;
    exp_t        ms;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (core_start_o) begin
          cs_cyc = cyc;
          chk("launch_while_busy", 64'(busy_o && !done_o), 64'd1);
          if (exp_base.size() == 0) fail_now("unexpected_core_start");
          else begin
            mb = exp_base.pop_front();
            chk("core_base", 64'(core_base_o), 64'(mb));
          end
        end
        if (done_o) begin
          if (exp_sum.size() == 0) fail_now("unexpected_done");
          else begin
            ms = exp_sum.pop_front();
            chk("found", 64'(found_o), 64'(ms.found));
            chk("found_nonce", 64'(found_nonce_o), 64'(ms.fn));
            chk("found_word", 64'(found_word_o), 64'(ms.fw));
            chk("batch_count", 64'(batch_count_o), 64'(ms.bc));
            chk("error", 64'(error_o), 64'(ms.err));
            if (ms.err) chk("timeout_latency", 64'(cyc - cs_cyc), 64'(TIMEOUT + 1));
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 64'({core_start_o, busy_o, done_o, found_o, error_o}), 64'd0);
    chk({tag, "_base"}, 64'(core_base_o), 64'd0);
    chk({tag, "_found_vals"}, {found_nonce_o, found_word_o}, 64'd0);
    chk({tag, "_bcount"}, 64'(batch_count_o), 64'd0);
  endtask

  task automatic recover();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_base.delete();
    exp_sum.delete();
    reset_n = 1'b1;
  endtask

  task automatic launch(input logic [31:0] lo, input logic [31:0] hi,
                        input logic [31:0] tgt, input logic stop);
    stub_batch = 0;
    @(negedge clk);
    nonce_lo_i    = lo;
    nonce_hi_i    = hi;
    target_i      = tgt;
    stop_on_hit_i = stop;
    start_i       = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_rise", 64'(busy_o), 64'd1);
    if (lo > hi) chk("empty_done_now", 64'(done_o), 64'd1);
    else chk("first_core_start", 64'(core_start_o), 64'd1);
    // Scramble config to show it was latched.
    nonce_hi_i    = $urandom;
    target_i      = $urandom;
    stop_on_hit_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      fail_now("done_never_seen");
      recover();
    end else begin
      @(posedge clk);
      #1;
      chk("busy_fall", 64'(busy_o), 64'd0);
      chk("done_single", 64'(done_o), 64'd0);
    end
    chk("bases_drained", 64'(exp_base.size()), 64'd0);
    chk("sums_drained", 64'(exp_sum.size()), 64'd0);
  endtask

  task automatic sweep(input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] tgt, input logic stop);
    model_push(lo, hi, tgt, stop);
    launch(lo, hi, tgt, stop);
    wait_done();
  endtask

  initial begin
    exp_t z;
    z             = '0;
    reset_n       = 1'b0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    stop_on_hit_i = 1'b0;
    nonce_lo_i    = '0;
    nonce_hi_i    = '0;
    target_i      = '0;
    clear_plan();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("reset_state");

    clear_plan();
    sweep(32'd0, 32'd47, 32'd0, 1'b0);

    clear_plan();
    add_res(0, 5, 32'h2000);
    add_res(0, 3, 32'h0800);
    sweep(32'd0, 32'd31, 32'h1000, 1'b1);

    clear_plan();
    add_res(0, 9, 32'd5);
    add_res(0, 2, 32'd7);
    sweep(32'h100, 32'h10F, 32'h10, 1'b0);

    clear_plan();
    add_res(0, 12, 32'd1);
    sweep(32'd10, 32'd20, 32'h100, 1'b0);

    clear_plan();
    add_res(0, 15, 32'd3);
    sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h100, 1'b0);

    clear_plan();
    add_res(0, 12, 32'd1);
    add_res(0, 7, 32'd2);
    sweep(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h100, 1'b0);

    clear_plan();
    sweep(32'd5, 32'd4, 32'h100, 1'b0);

    clear_plan();
    plan_hang[0] = 1'b1;
    sweep(32'h1000, 32'h2000, 32'h100, 1'b0);

    clear_plan();
    add_res(0, 1, 32'd4);
    plan_hang[1] = 1'b1;
    sweep(32'h3000, 32'h3100, 32'h100, 1'b0);

    // Abort in WAIT.
    clear_plan();
    plan_hang[0] = 1'b1;
    exp_base.push_back(32'h40);
    exp_sum.push_back(z);
    launch(32'h40, 32'h4000, 32'h10, 1'b0);
    repeat (4) @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    chk("abort_done_next", 64'(done_o), 64'd1);
    chk("abort_no_error", 64'(error_o), 64'd0);
    wait_done();

    // Start while busy must not disturb the sweep in flight.
    clear_plan();
    for (int k = 0; k < 4; k++) add_res(0, k + 4, 32'd300 + 32'(k));
    add_res(1, 1, 32'd9);
    model_push(32'h200, 32'h21F, 32'h100, 1'b0);
    launch(32'h200, 32'h21F, 32'h100, 1'b0);
    repeat (2) @(negedge clk);
    nonce_lo_i = 32'h9999_0000;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("busy_start_ignored", 64'(core_base_o), 64'h200);
    wait_done();

    // Asynchronous reset mid-WAIT after a recorded hit.
    clear_plan();
    add_res(0, 2, 32'd1);
    plan_hang[1] = 1'b1;
    exp_base.push_back(32'h80);
    exp_base.push_back(32'h90);
    launch(32'h80, 32'h1000, 32'h100, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_reset_found", 64'(found_o), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_zero("reset_mid_wait");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("bases_after_reset", 64'(exp_base.size()), 64'd0);

    for (int t = 0; t < 25; t++) begin
      logic [31:0]     lo, hi, tgt;
      logic            stop;
      longint unsigned h;
      clear_plan();
      lo = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 40)) : $urandom;
      h  = 64'(lo) + 64'($urandom_range(0, 100));
      hi = (h > 64'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(h);
      if (t % 9 == 4 && lo != 32'd0) hi = lo - 32'd1;
      tgt  = $urandom_range(1, 1 << 16);
      stop = 1'($urandom_range(0, 1));
      for (int b = 0; b < MaxB; b++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++) add_res(b, $urandom_range(0, LANES - 1), $urandom_range(0, 1 << 17));
      end
      sweep(lo, hi, tgt, stop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
